// File: rtl/usb_rx_bit_recovery_if.sv
// Line-side inputs and decoded-bit outputs of the USB RX bit recovery block.
// The master drives the synchronized lines; the slave returns the recovered bits.
interface usb_rx_bit_recovery_if;
   logic d_plus_sync;
   logic d_minus_sync;
   logic rx_enable;
   logic bit_valid;
   logic bit_out;
   logic stuff_err;
   logic eop;
   logic edge_det;

   modport master (
      output d_plus_sync, d_minus_sync, rx_enable,
      input  bit_valid, bit_out, stuff_err, eop, edge_det
   );

   modport slave (
      input  d_plus_sync, d_minus_sync, rx_enable,
      output bit_valid, bit_out, stuff_err, eop, edge_det
   );
endinterface

// File: rtl/usb_rx_bit_recovery.sv
// USB receive bit recovery: edge-resynchronised bit timer, NRZI decode,
// bit-unstuffing and SE0/EOP detection feeding the RX shift register.
module usb_rx_bit_recovery #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3,
   parameter int STUFF_LEN    = 6
) (
   input logic                  clk,
   input logic                  rst,
   usb_rx_bit_recovery_if.slave rx
);
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int ONES_W = $clog2(STUFF_LEN + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
   localparam logic [ONES_W-1:0] ONES_MAX   = ONES_W'(STUFF_LEN);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      SE0_SEEN = 2'd2,
      WAIT_J   = 2'd3
   } state_t;

   state_t            state_r, state_next_s;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic [ONES_W-1:0] ones_cnt_r, ones_next_s;
   logic              d_plus_prev_r, last_line_r, last_line_next_s;
   logic              edge_s, sample_s, se0_s, j_s, dec_s, decode_s;
   logic              bit_valid_r, bit_out_r, stuff_err_r, eop_r, edge_det_r;
   logic              bit_valid_next_s, bit_out_next_s, stuff_err_next_s, eop_next_s;

   assign edge_s   = rx.rx_enable & (rx.d_plus_sync ^ d_plus_prev_r);
   assign sample_s = rx.rx_enable & (bit_cnt_r == CNT_SAMPLE) & ~edge_s;
   assign se0_s    = ~rx.d_plus_sync & ~rx.d_minus_sync;
   assign j_s      = rx.d_plus_sync & ~rx.d_minus_sync;
   assign dec_s    = ~(rx.d_plus_sync ^ last_line_r);
   // SE1 is not special-cased: D+ alone is taken as the line level
   assign decode_s = sample_s & ~se0_s & ((state_r == RUN) | (state_r == SE0_SEEN));

   // Bit timer, restarted on every D+ transition, and previous-D+ tracker
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_r     <= {CNT_W{1'b0}};
         d_plus_prev_r <= 1'b1;
      end else begin
         d_plus_prev_r <= rx.d_plus_sync;
         if (!rx.rx_enable || edge_s) begin
            bit_cnt_r <= {CNT_W{1'b0}};
         end else if (bit_cnt_r == CNT_LAST) begin
            bit_cnt_r <= {CNT_W{1'b0}};
         end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; apart from IDLE entry/exit, moves only on sample cycles
   always_comb begin
      state_next_s = state_r;
      if (!rx.rx_enable) begin
         state_next_s = IDLE;
      end else begin
         case (state_r)
            IDLE:     state_next_s = RUN;
            RUN:      state_next_s = (sample_s && se0_s) ? SE0_SEEN : RUN;
            SE0_SEEN: begin
               if (sample_s) begin
                  state_next_s = se0_s ? WAIT_J : RUN;
               end else begin
                  state_next_s = SE0_SEEN;
               end
            end
            WAIT_J:   state_next_s = (sample_s && j_s) ? RUN : WAIT_J;
            default:  state_next_s = IDLE;
         endcase
      end
   end

   // Output and decode-history logic
   always_comb begin
      bit_valid_next_s = 1'b0;
      bit_out_next_s   = 1'b0;
      stuff_err_next_s = 1'b0;
      eop_next_s       = 1'b0;
      last_line_next_s = last_line_r;
      ones_next_s      = ones_cnt_r;
      if (!rx.rx_enable || (state_r == IDLE)) begin
         last_line_next_s = 1'b1;
         ones_next_s      = {ONES_W{1'b0}};
      end else if (decode_s) begin
         last_line_next_s = rx.d_plus_sync;
         if (ones_cnt_r == ONES_MAX) begin
            stuff_err_next_s = dec_s;
            ones_next_s      = {ONES_W{1'b0}};
         end else begin
            bit_valid_next_s = 1'b1;
            bit_out_next_s   = dec_s;
            ones_next_s      = dec_s ? (ones_cnt_r + ONES_W'(1)) : {ONES_W{1'b0}};
         end
      end else if (sample_s && (state_r == SE0_SEEN) && se0_s) begin
         eop_next_s = 1'b1;
      end else if (sample_s && (state_r == WAIT_J) && j_s) begin
         last_line_next_s = 1'b1;
         ones_next_s      = {ONES_W{1'b0}};
      end else begin
         last_line_next_s = last_line_r;
      end
   end

   // Decode history and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         last_line_r <= 1'b1;
         ones_cnt_r  <= {ONES_W{1'b0}};
         bit_valid_r <= 1'b0;
         bit_out_r   <= 1'b0;
         stuff_err_r <= 1'b0;
         eop_r       <= 1'b0;
         edge_det_r  <= 1'b0;
      end else begin
         last_line_r <= last_line_next_s;
         ones_cnt_r  <= ones_next_s;
         bit_valid_r <= bit_valid_next_s;
         bit_out_r   <= bit_out_next_s;
         stuff_err_r <= stuff_err_next_s;
         eop_r       <= eop_next_s;
         edge_det_r  <= edge_s;
      end
   end

   assign rx.bit_valid = bit_valid_r;
   assign rx.bit_out   = bit_out_r;
   assign rx.stuff_err = stuff_err_r;
   assign rx.eop       = eop_r;
   assign rx.edge_det  = edge_det_r;
endmodule

// File: tb/tb_usb_rx_bit_recovery.sv
// Directed bench for usb_rx_bit_recovery: a cycle-level behavioural model is
// compared every cycle, and per-scenario literal expectations pin the model.
module tb_usb_rx_bit_recovery;
   localparam int CPB   = 8;
   localparam int SP    = 3;
   localparam int STUFF = 6;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   usb_rx_bit_recovery_if bus ();

   usb_rx_bit_recovery #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP), .STUFF_LEN(STUFF)) dut (
      .clk (clk),
      .rst (rst),
      .rx  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model state
   int   m_cnt, m_ones;
   logic m_prev, m_last, m_active, m_se0, m_waitj;
   logic ex_valid, ex_bit, ex_serr, ex_eop, ex_edge;

   // Recorded DUT activity for literal checks
   logic bits_q [$];
   int   cyc_q  [$];
   int   serr_n, eop_n, any_n;
   logic [4:0] got, want;

   task automatic model_step();
      logic edge_v, smp, dec;
      ex_valid = 1'b0; ex_bit = 1'b0; ex_serr = 1'b0; ex_eop = 1'b0; ex_edge = 1'b0;
      if (rst) begin
         m_prev = 1'b1; m_cnt = 0; m_active = 1'b0; m_se0 = 1'b0;
         m_waitj = 1'b0; m_last = 1'b1; m_ones = 0;
         return;
      end
      edge_v  = bus.rx_enable && (bus.d_plus_sync != m_prev);
      smp     = bus.rx_enable && (m_cnt == SP) && !edge_v;
      ex_edge = edge_v;
      if (!bus.rx_enable) begin
         m_active = 1'b0; m_se0 = 1'b0; m_waitj = 1'b0;
      end else if (!m_active) begin
         m_active = 1'b1; m_last = 1'b1; m_ones = 0;
      end else if (smp) begin
         if (m_waitj) begin
            if (bus.d_plus_sync && !bus.d_minus_sync) begin
               m_waitj = 1'b0; m_last = 1'b1; m_ones = 0;
            end
         end else if (!bus.d_plus_sync && !bus.d_minus_sync) begin
            if (m_se0) begin
               ex_eop = 1'b1; m_se0 = 1'b0; m_waitj = 1'b1;
            end else begin
               m_se0 = 1'b1;
            end
         end else begin
            m_se0  = 1'b0;
            dec    = (bus.d_plus_sync == m_last);
            m_last = bus.d_plus_sync;
            if (m_ones == STUFF) begin
               ex_serr = dec;
               m_ones  = 0;
            end else begin
               ex_valid = 1'b1;
               ex_bit   = dec;
               m_ones   = dec ? m_ones + 1 : 0;
            end
         end
      end
      m_cnt  = (!bus.rx_enable || edge_v) ? 0 : (m_cnt + 1) % CPB;
      m_prev = bus.d_plus_sync;
   endtask

   // Compare process: outputs after each posedge against the model's prediction
   initial begin
      ex_valid = 1'b0; ex_bit = 1'b0; ex_serr = 1'b0; ex_eop = 1'b0; ex_edge = 1'b0;
      serr_n = 0; eop_n = 0; any_n = 0;
      forever begin
         @(negedge clk);
         got  = {bus.bit_valid, bus.bit_valid & bus.bit_out, bus.stuff_err, bus.eop, bus.edge_det};
         want = {ex_valid, ex_valid & ex_bit, ex_serr, ex_eop, ex_edge};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL cycle_outputs cyc=%0d {valid,bit,serr,eop,edge} got=%b expected=%b",
                     cyc, got, want);
         end
         if (bus.bit_valid === 1'b1) begin
            bits_q.push_back(bus.bit_out);
            cyc_q.push_back(cyc);
         end
         if (bus.stuff_err === 1'b1) serr_n++;
         if (bus.eop === 1'b1) eop_n++;
         if (|got) any_n++;
         model_step();
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_line(input byte c);
      if (c == "K") begin
         bus.d_plus_sync = 1'b0; bus.d_minus_sync = 1'b1;
      end else if (c == "J") begin
         bus.d_plus_sync = 1'b1; bus.d_minus_sync = 1'b0;
      end else if (c == "0") begin
         bus.d_plus_sync = 1'b0; bus.d_minus_sync = 1'b0;
      end else begin
         bus.d_plus_sync = 1'b1; bus.d_minus_sync = 1'b1;
      end
   endtask

   // One character per bit period: K, J, 0 = SE0, 1 = SE1
   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         drive_line(s[i]);
         step(CPB);
      end
   endtask

   task automatic begin_pkt();
      bus.rx_enable = 1'b0;
      drive_line("J");
      step(3);
      bits_q.delete(); cyc_q.delete(); serr_n = 0; eop_n = 0;
      bus.rx_enable = 1'b1;
      step(2);
   endtask

   task automatic end_pkt();
      bus.rx_enable = 1'b0;
      step(3);
   endtask

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_bits(input string name, input string exp);
      string act;
      act = "";
      foreach (bits_q[i]) act = {act, bits_q[i] ? "1" : "0"};
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got bits '%s', expected '%s'", name, act, exp);
      end
   endtask

   int t0, t1;

   initial begin
      rst = 1'b1;
      bus.rx_enable = 1'b1;
      drive_line("J");
      // Reset held two cycles while the lines toggle
      step(1);
      drive_line("K");
      step(1);
      rst = 1'b0;
      bus.rx_enable = 1'b0;
      drive_line("J");
      step(2);
      check_eq("reset_quiet_outputs", any_n, 0);

      // Bit timing after a K edge
      begin_pkt();
      drive_line("K");
      t0 = cyc;
      step(2 * CPB);
      end_pkt();
      check_eq("timing_strobes", cyc_q.size(), 2);
      if (cyc_q.size() >= 2) begin
         check_eq("timing_first_strobe", cyc_q[0] - t0, 5);
         check_eq("timing_second_strobe", cyc_q[1] - t0, 13);
      end
      check_bits("timing_bits", "01");

      // NRZI decode of sync pattern
      begin_pkt();
      send_str("KJKJKJKK");
      end_pkt();
      check_bits("nrzi_sync", "00000001");

      // Six 1s, stuff 0, then a 1
      begin_pkt();
      send_str("JJJJJJKK");
      end_pkt();
      check_bits("stuff_ok_bits", "1111111");
      check_eq("stuff_ok_err", serr_n, 0);

      // Seven 1s: stuff violation
      begin_pkt();
      send_str("JJJJJJJ");
      end_pkt();
      check_bits("stuff_bad_bits", "111111");
      check_eq("stuff_bad_err", serr_n, 1);

      // Packet, EOP, then a fresh packet
      begin_pkt();
      send_str("KJKJKJKKKJ00JKJKK");
      end_pkt();
      check_bits("eop_bits", "00000001100001");
      check_eq("eop_count", eop_n, 1);

      // Single-bit SE0 glitch
      begin_pkt();
      send_str("K0JJ");
      end_pkt();
      check_bits("glitch_bits", "001");
      check_eq("glitch_eop", eop_n, 0);

      // SE1 decodes as line high, no flags
      begin_pkt();
      send_str("K1");
      end_pkt();
      check_bits("se1_bits", "00");
      check_eq("se1_err", serr_n + eop_n, 0);

      // Early edge resync, then rx_enable dropped mid-bit
      begin_pkt();
      drive_line("K");
      t0 = cyc;
      step(6);
      drive_line("J");
      t1 = cyc;
      step(16);
      bus.rx_enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive_line((i % 2 == 0) ? "K" : "J");
         step(4);
      end
      check_eq("resync_strobes", cyc_q.size(), 3);
      if (cyc_q.size() >= 3) begin
         check_eq("resync_first", cyc_q[0] - t0, 5);
         check_eq("resync_shifted", cyc_q[1] - t1, 5);
         check_eq("resync_next", cyc_q[2] - t1, 13);
      end
      check_bits("resync_bits", "001");

      // Reset in the middle of a packet
      begin_pkt();
      send_str("KJ");
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      send_str("KJK");
      end_pkt();
      check_bits("midrst_bits", "00000");

      step(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
